fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Write-side counterpart of the VGA scan-out path.
- Accepts a 12-bit RGB pixel stream from the image-processing pipeline (LBP output or camera) over a valid/ready handshake with start-of-frame marking.
- Generates write enable, address and data for the shared frame-buffer BRAM, which the VGA reader scans linearly from 0 to H_RES*V_RES-1.
- Supports the same four display modes as the reader's cmd input (normal, normal, 2x decimate, horizontal mirror), applied at write time.

Parameters:
- H_RES, 400, pixels per input row (even).
- V_RES, 300, rows per input frame (even).
- ADDR_W, 19, frame-buffer address width.
- DATA_W, 12, pixel width (4:4:4 RGB).

Ports:
- clk_25mHz  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd  in  2  mode: 0/1 normal, 2 decimate, 3 mirror; sampled only on SOF transfer.
- s_valid  in  1  input pixel valid.
- s_ready  out  1  writer can accept a pixel.
- s_sof  in  1  marks the current pixel as (0,0) of a frame.
- s_data  in  DATA_W  input pixel.
- wr_en  out  1  frame-buffer write strobe.
- wr_addr  out  ADDR_W  frame-buffer write address.
- wr_data  out  DATA_W  frame-buffer write data.
- busy  out  1  frame capture in progress.
- frame_done  out  1  one-cycle pulse at end of frame.
- sof_err  out  1  one-cycle pulse on an SOF received mid-frame.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; wr_en, wr_addr, wr_data, frame_done, sof_err, busy all 0; internal x, y, row_base and mode cleared. s_ready=1 during reset.
- A transfer occurs when s_valid && s_ready on a rising edge.
- s_ready = (state != DONE).
- busy = (state != IDLE).
- States:
  - IDLE: transfers with s_sof=0 are discarded (no write). A transfer with s_sof=1 latches cmd into mode, treats the pixel as (0,0), processes it, then moves to CAPTURE.
  - CAPTURE: each transfer advances x. When x=H_RES-1: x wraps to 0, y increments, row_base += H_RES. Transfer of pixel (H_RES-1, V_RES-1) moves to DONE.
  - DONE: lasts exactly 1 cycle with s_ready=0 and frame_done=1, then returns to IDLE.
- Address generation uses no multiplier: row_base accumulator plus x, or plus H_RES-1-x. Decimate mode uses a separate output-address counter.
- Write rules, per accepted pixel (x,y):
  - mode 0/1: always write; addr = y*H_RES + x.
  - mode 3 (mirror): always write; addr = y*H_RES + (H_RES-1-x).
  - mode 2 (decimate): write only if x and y are both even; addr = (y/2)*(H_RES/2) + x/2, i.e. sequential 0..(H_RES*V_RES/4)-1.
- Latency: wr_en/wr_addr/wr_data are registered and appear exactly 1 cycle after the accepted transfer.
  - wr_en=0 in all other cycles.
  - wr_addr and wr_data hold their last value when wr_en=0.
- The final write of a frame coincides with frame_done.
- Mid-frame SOF (CAPTURE, s_sof=1 transfer):
  - Abort the current frame; no frame_done.
  - Relatch cmd and restart at (0,0) with this pixel.
  - sof_err pulses for 1 cycle, aligned with that pixel's write.
- An SOF on the last pixel of a frame is treated as a mid-frame SOF: restart, no DONE.
- cmd changes outside an SOF transfer are ignored.
- s_valid gaps stall the counters; there is no timeout.
- Reset mid-frame: immediate return to reset values; the next frame requires an SOF.

Test Plan:
- Normal mode, cmd=0, 120000 back-to-back pixels with SOF on first:
  - writes at addr 0..119999 with data equal to the input, each 1 cycle after its transfer.
  - frame_done and s_ready=0 for one cycle together with the write to 119999; busy then 0.
- Mirror, cmd=3:
  - pixel index 0 -> addr 399, index 399 -> addr 0, index 400 -> addr 799.
  - last pixel -> addr 119600.
  - frame_done asserted.
- Decimate, cmd=2:
  - index 0 -> addr 0, index 2 -> addr 1; index 1 and indices 400..799 produce no write.
  - index 800 -> addr 200; last write addr 29999.
  - exactly 30000 wr_en pulses in the frame.
- Pre-SOF and stall:
  - 5 pixels without SOF in IDLE -> no writes, busy=0.
  - Then an SOF frame with random s_valid gaps -> contiguous addresses, no gaps or duplicates.
- Mid-frame SOF:
  - After 1000 pixels (cmd=0), SOF with cmd=3 -> sof_err pulse, that pixel written to addr 399.
  - No frame_done until 120000 further pixels.
- Reset mid-frame:
  - rst_n low at pixel 5000 -> all outputs 0 asynchronously, busy=0.
  - After release, non-SOF pixels are ignored; a new SOF frame starts at addr 0.

Source files
------------

// File: rtl/fb_pixel_writer.sv
// Frame-buffer write side: turns a valid/ready pixel stream with SOF marking into
// registered BRAM write strobes, applying normal, 2x-decimate or mirror layout.
module fb_pixel_writer #(
    parameter int H_RES  = 400,
    parameter int V_RES  = 300,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 12
) (
    input  logic              clk_25mHz,
    input  logic              rst_n,
    input  logic [1:0]        cmd,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_sof,
    input  logic [DATA_W-1:0] s_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              sof_err
);

    localparam int XW = $clog2(H_RES);
    localparam int YW = $clog2(V_RES);
    localparam logic [XW-1:0]     X_LAST   = XW'(H_RES - 1);
    localparam logic [YW-1:0]     Y_LAST   = YW'(V_RES - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(H_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] dec_addr_q, dec_addr_d;
    logic [1:0]        mode_q, mode_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              sof_err_q, sof_err_d;

    // An SOF pixel is processed as (0,0) of a fresh frame using the live cmd.
    logic              take;
    logic [XW-1:0]     eff_x;
    logic [YW-1:0]     eff_y;
    logic [ADDR_W-1:0] eff_rb;
    logic [ADDR_W-1:0] eff_dec;
    logic [1:0]        eff_mode;

    assign s_ready    = (state_q != ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign sof_err    = sof_err_q;

    assign take     = s_valid && s_ready && (s_sof || (state_q == ST_CAPTURE));
    assign eff_x    = s_sof ? '0 : x_q;
    assign eff_y    = s_sof ? '0 : y_q;
    assign eff_rb   = s_sof ? '0 : row_base_q;
    assign eff_dec  = s_sof ? '0 : dec_addr_q;
    assign eff_mode = s_sof ? cmd : mode_q;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        dec_addr_d = dec_addr_q;
        mode_d     = mode_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        sof_err_d  = 1'b0;

        if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end else if (take) begin
            sof_err_d  = s_sof && (state_q == ST_CAPTURE);
            mode_d     = eff_mode;
            dec_addr_d = eff_dec;

            unique case (eff_mode)
                2'd2: begin
                    if (!eff_x[0] && !eff_y[0]) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = eff_dec;
                        wr_data_d  = s_data;
                        dec_addr_d = eff_dec + ADDR_W'(1);
                    end
                end
                2'd3: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = eff_rb + COL_LAST - ADDR_W'(eff_x);
                    wr_data_d = s_data;
                end
                default: begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = eff_rb + ADDR_W'(eff_x);
                    wr_data_d = s_data;
                end
            endcase

            // Raster advance; the last pixel of the frame parks counters at origin.
            if (eff_x == X_LAST) begin
                x_d = '0;
                if (eff_y == Y_LAST) begin
                    y_d        = '0;
                    row_base_d = '0;
                    state_d    = ST_DONE;
                end else begin
                    y_d        = eff_y + YW'(1);
                    row_base_d = eff_rb + ROW_STEP;
                    state_d    = ST_CAPTURE;
                end
            end else begin
                x_d        = eff_x + XW'(1);
                y_d        = eff_y;
                row_base_d = eff_rb;
                state_d    = ST_CAPTURE;
            end
        end
    end

    always_ff @(posedge clk_25mHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            row_base_q <= '0;
            dec_addr_q <= '0;
            mode_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            sof_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
            dec_addr_q <= dec_addr_d;
            mode_q     <= mode_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            sof_err_q  <= sof_err_d;
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer on a reduced 40x30 frame: a hand-derived vector table,
// then directed and random streams checked cycle by cycle against a raster model.
module tb_fb_pixel_writer;

    localparam int H  = 40;
    localparam int V  = 30;
    localparam int AW = 19;
    localparam int DW = 12;
    localparam int NPIX = H * V;

    logic          clk_25mHz;
    logic          rst_n;
    logic [1:0]    cmd;
    logic          s_valid;
    logic          s_ready;
    logic          s_sof;
    logic [DW-1:0] s_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          frame_done;
    logic          sof_err;

    fb_pixel_writer #(.H_RES(H), .V_RES(V), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_25mHz (clk_25mHz),
        .rst_n     (rst_n),
        .cmd       (cmd),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_sof     (s_sof),
        .s_data    (s_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .frame_done(frame_done),
        .sof_err   (sof_err)
    );

    initial clk_25mHz = 1'b0;
    always #20 clk_25mHz = ~clk_25mHz;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    int se_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: frame position is a plain pixel index; coordinates and
    // addresses come straight from the address formulas via divide/modulo.
    int           m_state;   // 0 idle, 1 capture, 2 done
    int           m_idx;
    logic [1:0]   m_mode;
    logic         exp_we, exp_fd, exp_serr, exp_ready, exp_busy;
    int           exp_addr;
    logic [DW-1:0] exp_data;

    task automatic model_reset();
        m_state = 0; m_idx = 0; m_mode = 2'd0;
        exp_we = 0; exp_fd = 0; exp_serr = 0; exp_ready = 1; exp_busy = 0;
        exp_addr = 0; exp_data = '0;
    endtask

    task automatic model_pixel(input logic [DW-1:0] d);
        int x, y;
        x = m_idx % H;
        y = m_idx / H;
        if (m_mode == 2'd2) begin
            if ((x % 2 == 0) && (y % 2 == 0)) begin
                exp_we = 1; exp_addr = (y / 2) * (H / 2) + x / 2; exp_data = d;
            end
        end else if (m_mode == 2'd3) begin
            exp_we = 1; exp_addr = y * H + (H - 1 - x); exp_data = d;
        end else begin
            exp_we = 1; exp_addr = y * H + x; exp_data = d;
        end
        m_idx++;
        m_state = (m_idx == NPIX) ? 2 : 1;
        if (m_state == 2) m_idx = 0;
    endtask

    task automatic model_step(input logic v, input logic sof, input logic [1:0] c,
                              input logic [DW-1:0] d);
        exp_we = 0; exp_serr = 0;
        if (m_state == 2) begin
            m_state = 0;
        end else if (v) begin
            if (sof) begin
                if (m_state == 1) exp_serr = 1;
                m_mode = c;
                m_idx = 0;
                model_pixel(d);
            end else if (m_state == 1) begin
                model_pixel(d);
            end
        end
        exp_fd    = (m_state == 2);
        exp_ready = (m_state != 2);
        exp_busy  = (m_state != 0);
    endtask

    task automatic check_outputs();
        chk("wr_en", wr_en, exp_we);
        chk("wr_addr", wr_addr, exp_addr);
        chk("wr_data", wr_data, exp_data);
        chk("frame_done", frame_done, exp_fd);
        chk("sof_err", sof_err, exp_serr);
        chk("s_ready", s_ready, exp_ready);
        chk("busy", busy, exp_busy);
        if (wr_en) wr_cnt++;
        if (frame_done) fd_cnt++;
        if (sof_err) se_cnt++;
    endtask

    // One clock: check what the previous edge produced, then drive the next beat.
    task automatic cyc(input logic v, input logic sof, input logic [1:0] c,
                       input logic [DW-1:0] d);
        @(negedge clk_25mHz);
        check_outputs();
        s_valid = v; s_sof = sof; cmd = c; s_data = d;
        model_step(v, sof, c, d);
        @(posedge clk_25mHz);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'($urandom), DW'($urandom));
    endtask

    task automatic reset_dut();
        @(negedge clk_25mHz);
        rst_n = 0; s_valid = 0; s_sof = 0; cmd = 0; s_data = '0;
        @(negedge clk_25mHz);
        rst_n = 1;
        model_reset();
    endtask

    task automatic send_frame(input logic [1:0] c, input bit gaps);
        for (int i = 0; i < NPIX; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0))
                cyc(1'b0, 1'($urandom), 2'($urandom), DW'($urandom));
            cyc(1'b1, (i == 0), (i == 0) ? c : 2'($urandom), DW'($urandom));
        end
    endtask

    task automatic clear_counts();
        wr_cnt = 0; fd_cnt = 0; se_cnt = 0;
    endtask

    typedef struct {
        logic          v;
        logic          sof;
        logic [1:0]    c;
        logic [DW-1:0] d;
        logic          e_we;
        int            e_addr;
        logic [DW-1:0] e_data;
        logic          e_serr;
        logic          e_busy;
    } vec_t;

    vec_t vecs[9];

    initial begin
        rst_n = 0; s_valid = 0; s_sof = 0; cmd = 0; s_data = '0;
        model_reset();

        vecs[0] = '{1, 0, 2'd0, 12'h111, 0, 0,     12'h000, 0, 0};
        vecs[1] = '{1, 1, 2'd3, 12'hA01, 1, H - 1, 12'hA01, 0, 1};
        vecs[2] = '{1, 0, 2'd0, 12'hB02, 1, H - 2, 12'hB02, 0, 1};
        vecs[3] = '{0, 0, 2'd0, 12'hFFF, 0, H - 2, 12'hB02, 0, 1};
        vecs[4] = '{1, 1, 2'd2, 12'hC03, 1, 0,     12'hC03, 1, 1};
        vecs[5] = '{1, 0, 2'd1, 12'hD04, 0, 0,     12'hC03, 0, 1};
        vecs[6] = '{1, 0, 2'd3, 12'hE05, 1, 1,     12'hE05, 0, 1};
        vecs[7] = '{1, 1, 2'd0, 12'hF06, 1, 0,     12'hF06, 1, 1};
        vecs[8] = '{1, 0, 2'd0, 12'h123, 1, 1,     12'h123, 0, 1};

        repeat (3) @(posedge clk_25mHz);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_s_ready", s_ready, 1);
        chk("rst_busy", busy, 0);
        @(negedge clk_25mHz);
        rst_n = 1;

        for (int i = 0; i < 9; i++) begin
            @(negedge clk_25mHz);
            s_valid = vecs[i].v; s_sof = vecs[i].sof; cmd = vecs[i].c; s_data = vecs[i].d;
            @(posedge clk_25mHz);
            #1;
            chk("vec_wr_en", wr_en, vecs[i].e_we);
            chk("vec_wr_addr", wr_addr, vecs[i].e_addr);
            chk("vec_wr_data", wr_data, vecs[i].e_data);
            chk("vec_sof_err", sof_err, vecs[i].e_serr);
            chk("vec_busy", busy, vecs[i].e_busy);
            $display("vector %0d: v=%0d sof=%0d cmd=%0d -> wr_en=%0d addr=%0d", i,
                     vecs[i].v, vecs[i].sof, vecs[i].c, wr_en, wr_addr);
        end

        reset_dut();
        clear_counts();
        send_frame(2'd0, 0);
        idle_cycles(3);
        chk("normal_writes", wr_cnt, NPIX);
        chk("normal_frame_done", fd_cnt, 1);
        $display("normal frame: writes=%0d frame_done=%0d", wr_cnt, fd_cnt);

        clear_counts();
        send_frame(2'd3, 0);
        idle_cycles(3);
        chk("mirror_writes", wr_cnt, NPIX);
        chk("mirror_frame_done", fd_cnt, 1);
        $display("mirror frame: writes=%0d frame_done=%0d", wr_cnt, fd_cnt);

        clear_counts();
        send_frame(2'd2, 0);
        idle_cycles(3);
        chk("decimate_writes", wr_cnt, NPIX / 4);
        chk("decimate_frame_done", fd_cnt, 1);
        $display("decimate frame: writes=%0d frame_done=%0d", wr_cnt, fd_cnt);

        clear_counts();
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 2'd0, DW'($urandom));
        send_frame(2'd1, 1);
        idle_cycles(3);
        chk("gap_writes", wr_cnt, NPIX);
        chk("gap_frame_done", fd_cnt, 1);
        $display("pre-sof and stalled frame: writes=%0d frame_done=%0d", wr_cnt, fd_cnt);

        clear_counts();
        for (int i = 0; i < 100; i++) cyc(1'b1, (i == 0), 2'd0, DW'($urandom));
        send_frame(2'd3, 0);
        idle_cycles(3);
        chk("midsof_err_pulses", se_cnt, 1);
        chk("midsof_frame_done", fd_cnt, 1);
        $display("mid-frame sof: sof_err=%0d frame_done=%0d", se_cnt, fd_cnt);

        clear_counts();
        for (int i = 0; i < NPIX; i++) cyc(1'b1, 1'b1, 2'd0, DW'($urandom));
        for (int i = 0; i < NPIX - 1; i++) cyc(1'b1, 1'b0, 2'd0, DW'($urandom));
        cyc(1'b1, 1'b1, 2'd3, DW'($urandom));
        for (int i = 0; i < NPIX - 1; i++) cyc(1'b1, 1'b0, 2'd0, DW'($urandom));
        idle_cycles(3);
        chk("last_sof_frame_done", fd_cnt, 1);
        $display("sof on last pixel: sof_err=%0d frame_done=%0d", se_cnt, fd_cnt);

        clear_counts();
        for (int i = 0; i < 500; i++) cyc(1'b1, (i == 0), 2'd0, DW'($urandom));
        #3;
        rst_n = 0;
        #1;
        chk("arst_wr_en", wr_en, 0);
        chk("arst_wr_addr", wr_addr, 0);
        chk("arst_wr_data", wr_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_frame_done", frame_done, 0);
        chk("arst_sof_err", sof_err, 0);
        chk("arst_s_ready", s_ready, 1);
        @(negedge clk_25mHz);
        s_valid = 0; s_sof = 0;
        rst_n = 1;
        model_reset();
        clear_counts();
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 2'd0, DW'($urandom));
        send_frame(2'd0, 1);
        idle_cycles(3);
        chk("post_reset_writes", wr_cnt, NPIX);
        $display("reset mid-frame: post-reset writes=%0d", wr_cnt);

        clear_counts();
        for (int i = 0; i < 3000; i++)
            cyc(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 299) == 0),
                2'($urandom), DW'($urandom));
        idle_cycles(2);
        $display("random stream: writes=%0d sof_err=%0d", wr_cnt, se_cnt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
